reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 26 ++
 rtl/reg_scoreboard_sb_match.sv | 45 ++++
 rtl/reg_scoreboard.sv | 87 ++++++++
 tb/tb_reg_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: forwarding select codes,
// the Tnew field width and the per-stage slot record.
package reg_scoreboard_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam int TNEW_W = 2;

  typedef struct packed {
    logic              valid;
    logic [4:0]        a3;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  // A slot moving one stage down the pipe is one cycle closer to its result;
  // Tnew bottoms out at zero.
  function automatic slot_t slot_age(input slot_t s);
    slot_t r;
    r = s;
    if (s.tnew != '0) r.tnew = s.tnew - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_match.sv
// One read port of the scoreboard: finds the youngest in-flight writer of the
// requested register and decides between stalling and forwarding.
module sb_match
  import reg_scoreboard_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  slot_t [NSTAGE-1:0] slots_i,
  input  logic  [4:0]        addr_i,
  input  logic  [1:0]        tuse_i,
  output logic               stall_req_o,
  output logic  [1:0]        fwd_sel_o
);

  logic  hit;
  int    hit_idx;
  slot_t hit_slot;

  // Scan oldest to youngest so the youngest matching slot is the one kept;
  // register $0 is never produced, so it never matches.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 0;
    hit_slot = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (slots_i[i].valid && (slots_i[i].a3 == addr_i) && (addr_i != 5'd0)) begin
        hit      = 1'b1;
        hit_idx  = i;
        hit_slot = slots_i[i];
      end
    end
  end

  // Stall when the value arrives later than the reader needs it; forward only
  // from E or M once the result exists, W is covered by the GRF write bypass.
  always_comb begin
    stall_req_o = hit && (hit_slot.tnew > tuse_i);
    fwd_sel_o   = FWD_GRF;
    if (hit && (hit_slot.tnew == '0)) begin
      if (hit_idx == 0)      fwd_sel_o = FWD_E;
      else if (hit_idx == 1) fwd_sel_o = FWD_M;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a classic pipeline: tracks destination/Tnew of the
// instructions in E, M and W and drives stall and forwarding selects for the
// two D-stage read ports.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IssueValid,
  input  logic        IssueRegWrite,
  input  logic [4:0]  IssueA3,
  input  logic [1:0]  IssueTnew,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [1:0]  Tuse1,
  input  logic [1:0]  Tuse2,
  output logic        Stall,
  output logic [1:0]  Fwd1Sel,
  output logic [1:0]  Fwd2Sel,
  output logic [31:0] StallCnt
);

  slot_t [NSTAGE-1:0] slots_q;
  slot_t [NSTAGE-1:0] slots_d;
  slot_t              e_slot_d;
  logic  [31:0]       stall_cnt_q;
  logic  [31:0]       stall_cnt_d;
  logic               stall1;
  logic               stall2;

  sb_match #(.NSTAGE(NSTAGE)) u_match1 (
    .slots_i     (slots_q),
    .addr_i      (A1),
    .tuse_i      (Tuse1),
    .stall_req_o (stall1),
    .fwd_sel_o   (Fwd1Sel)
  );

  sb_match #(.NSTAGE(NSTAGE)) u_match2 (
    .slots_i     (slots_q),
    .addr_i      (A2),
    .tuse_i      (Tuse2),
    .stall_req_o (stall2),
    .fwd_sel_o   (Fwd2Sel)
  );

  assign Stall    = stall1 | stall2;
  assign StallCnt = stall_cnt_q;

  // New E contents: the issuing instruction, or a bubble when stalled/idle.
  always_comb begin
    e_slot_d = '0;
    if (!Stall && IssueValid) begin
      e_slot_d.valid = IssueRegWrite && (IssueA3 != 5'd0);
      e_slot_d.a3    = IssueA3;
      e_slot_d.tnew  = IssueTnew;
    end
  end

  // Shift the pipe: each older stage takes the aged contents of the younger.
  always_comb begin
    slots_d[0] = e_slot_d;
    for (int i = 1; i < NSTAGE; i++) begin
      slots_d[i] = slot_age(slots_q[i-1]);
    end
  end

  // Stall counter saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers; reset wipes every in-flight instruction at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios followed by
// random traffic, checked against an instruction-level model of the pipe.
module tb_reg_scoreboard;

  localparam int NSTAGE = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IssueValid = 1'b0;
  logic        IssueRegWrite = 1'b0;
  logic [4:0]  IssueA3 = '0;
  logic [1:0]  IssueTnew = '0;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [1:0]  Tuse1 = '0;
  logic [1:0]  Tuse2 = '0;
  logic        Stall;
  logic [1:0]  Fwd1Sel;
  logic [1:0]  Fwd2Sel;
  logic [31:0] StallCnt;

  reg_scoreboard #(.NSTAGE(NSTAGE)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .IssueValid    (IssueValid),
    .IssueRegWrite (IssueRegWrite),
    .IssueA3       (IssueA3),
    .IssueTnew     (IssueTnew),
    .A1            (A1),
    .A2            (A2),
    .Tuse1         (Tuse1),
    .Tuse2         (Tuse2),
    .Stall         (Stall),
    .Fwd1Sel       (Fwd1Sel),
    .Fwd2Sel       (Fwd2Sel),
    .StallCnt      (StallCnt)
  );

  always #5 Clk = ~Clk;

  // Expected response for one cycle.
  typedef struct {
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  // One in-flight register writer: destination, latency at issue, and how
  // many edges it has spent in the pipe since entering E.
  typedef struct {
    logic [4:0] dst;
    int         tnew;
    int         age;
  } ins_t;

  exp_t exp_q[$];
  ins_t flight[$];
  int   model_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: the youngest writer of the register decides; its remaining
  // latency is Tnew minus time spent in flight.
  function automatic void port_ref(input logic [4:0] a, input int tuse,
                                   output logic stall, output logic [1:0] sel);
    int best = -1;
    int rem;
    stall = 1'b0;
    sel   = 2'd0;
    if (a == 5'd0) return;
    foreach (flight[k]) begin
      if (flight[k].dst == a && (best < 0 || flight[k].age < flight[best].age)) best = k;
    end
    if (best < 0) return;
    rem = flight[best].tnew - flight[best].age;
    if (rem < 0) rem = 0;
    stall = (rem > tuse);
    if (rem == 0 && flight[best].age == 0) sel = 2'd1;
    if (rem == 0 && flight[best].age == 1) sel = 2'd2;
  endfunction

  // Drive one cycle's inputs on the falling edge, queue the expectation, then
  // advance the model across the coming rising edge.
  task automatic cyc(input string tag, input logic rst, input logic iv, input logic rw,
                     input logic [4:0] a3, input logic [1:0] tn,
                     input logic [4:0] a1, input logic [1:0] tu1,
                     input logic [4:0] a2, input logic [1:0] tu2);
    exp_t e;
    logic s1, s2;
    ins_t n;
    @(negedge Clk);
    Reset = rst; IssueValid = iv; IssueRegWrite = rw; IssueA3 = a3; IssueTnew = tn;
    A1 = a1; Tuse1 = tu1; A2 = a2; Tuse2 = tu2;
    if (rst) begin
      flight.delete();
      model_cnt = 0;
    end
    port_ref(a1, int'(tu1), s1, e.f1);
    port_ref(a2, int'(tu2), s2, e.f2);
    e.stall = s1 | s2;
    e.cnt   = model_cnt;
    e.tag   = tag;
    exp_q.push_back(e);
    if (!rst) begin
      if (e.stall) model_cnt++;
      foreach (flight[k]) flight[k].age++;
      for (int k = flight.size() - 1; k >= 0; k--)
        if (flight[k].age >= NSTAGE) flight.delete(k);
      if (iv && !e.stall && rw && a3 != 5'd0) begin
        n.dst = a3; n.tnew = int'(tn); n.age = 0;
        flight.push_back(n);
      end
    end
  endtask

  task automatic idle(input string tag, input logic [4:0] a1, input logic [1:0] tu1,
                      input logic [4:0] a2, input logic [1:0] tu2);
    cyc(tag, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, a1, tu1, a2, tu2);
  endtask

  // Monitor: every cycle, after the DUT has settled, compare against the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        $display("vec %0d %s: stall=%0b f1=%0d f2=%0d cnt=%0d", vectors, e.tag,
                 Stall, Fwd1Sel, Fwd2Sel, StallCnt);
        if (Stall !== e.stall) begin
          miscompares++;
          $display("FAIL %s stall: got %0b want %0b", e.tag, Stall, e.stall);
        end
        if (Fwd1Sel !== e.f1) begin
          miscompares++;
          $display("FAIL %s fwd1: got %0d want %0d", e.tag, Fwd1Sel, e.f1);
        end
        if (Fwd2Sel !== e.f2) begin
          miscompares++;
          $display("FAIL %s fwd2: got %0d want %0d", e.tag, Fwd2Sel, e.f2);
        end
        if (StallCnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s stallcnt: got %0d want %0d", e.tag, StallCnt, e.cnt);
        end
      end
    end
  end

  initial begin
    int budget;
    logic r;
    // Reset state, including Issue activity while held in reset.
    cyc("reset", 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    cyc("reset_iss", 1'b1, 1'b1, 1'b1, 5'd5, 2'd2, 5'd5, 2'd0, 5'd5, 2'd0);

    // Load-use: two stall cycles, then the value comes from W via the GRF.
    cyc("load5", 1'b0, 1'b1, 1'b1, 5'd5, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    cyc("lu_st1", 1'b0, 1'b1, 1'b1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0);
    cyc("lu_st2", 1'b0, 1'b1, 1'b1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0);
    cyc("lu_go", 1'b0, 1'b1, 1'b1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0);
    repeat (3) idle("drain", 5'd0, 2'd0, 5'd0, 2'd0);

    // ALU result: no forward while in E at Tnew=1, forward from M next cycle.
    cyc("alu8", 1'b0, 1'b1, 1'b1, 5'd8, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    idle("alu_e", 5'd0, 2'd0, 5'd8, 2'd1);
    idle("alu_m", 5'd0, 2'd0, 5'd8, 2'd1);
    repeat (2) idle("drain", 5'd0, 2'd0, 5'd0, 2'd0);

    // jal to $31: both ports forward from E.
    cyc("jal31", 1'b0, 1'b1, 1'b1, 5'd31, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    idle("jal_use", 5'd31, 2'd0, 5'd31, 2'd0);
    repeat (2) idle("drain", 5'd0, 2'd0, 5'd0, 2'd0);

    // Two writers of $3: E must win over M.
    cyc("w3_a", 1'b0, 1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    cyc("w3_b", 1'b0, 1'b1, 1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    idle("e_wins", 5'd3, 2'd0, 5'd3, 2'd2);
    repeat (2) idle("drain", 5'd0, 2'd0, 5'd0, 2'd0);

    // Writes to $0 never match.
    cyc("w0", 1'b0, 1'b1, 1'b1, 5'd0, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    idle("r0_e", 5'd0, 2'd0, 5'd0, 2'd0);
    idle("r0_m", 5'd0, 2'd0, 5'd0, 2'd0);

    // Reset during a stall: stall and counter drop at once, load is forgotten.
    cyc("load7", 1'b0, 1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    idle("st7", 5'd7, 2'd0, 5'd0, 2'd0);
    cyc("rst_mid", 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0);
    idle("post_rst", 5'd7, 2'd0, 5'd7, 2'd0);
    idle("post_rst2", 5'd7, 2'd0, 5'd7, 2'd0);

    // Random traffic over a small register set to provoke frequent hazards.
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) == 0);
      cyc("rand", r, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
          2'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
          5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
    end

    // Let the monitor consume the last expectation, with a bounded wait.
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
